// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// alu_arbiter_if : request/response channels of both requesters plus ALU bus
// Revision 1.0
// ============================================================================
interface alu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_in1;
    logic [31:0] req0_in2;
    logic [3:0]  req0_ctr;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_in1;
    logic [31:0] req1_in2;
    logic [3:0]  req1_ctr;

    logic        rsp0_valid;
    logic        rsp0_ready;
    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [31:0] rsp_res;
    logic        rsp_zero;
    logic        rsp_err;

    logic [31:0] alu_input1;
    logic [31:0] alu_input2;
    logic [3:0]  alu_ctr;
    logic        alu_src;
    logic [31:0] alu_res;
    logic        alu_zero;

    modport slave (
        input  req0_valid, req0_in1, req0_in2, req0_ctr,
        input  req1_valid, req1_in1, req1_in2, req1_ctr,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_res, rsp_zero, rsp_err,
        input  rsp0_ready, rsp1_ready,
        output alu_input1, alu_input2, alu_ctr, alu_src,
        input  alu_res, alu_zero
    );

    modport master (
        output req0_valid, req0_in1, req0_in2, req0_ctr,
        output req1_valid, req1_in1, req1_in2, req1_ctr,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_res, rsp_zero, rsp_err,
        output rsp0_ready, rsp1_ready,
        input  alu_input1, alu_input2, alu_ctr, alu_src,
        output alu_res, alu_zero
    );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// alu_arbiter : round-robin sharing of one 32-bit ALU between two requesters
// Revision 1.0
// ============================================================================
module alu_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    alu_arbiter_if.slave     bus,
    output logic [CNT_W-1:0] op_count,
    output logic             busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        last_grant;
    logic        grant;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] result;
    logic        zero_flag;
    logic        err_flag;

    logic        take0;
    logic        take1;
    logic        accept;
    logic        legal;
    logic        done;
    logic [31:0] sel_in1;
    logic [31:0] sel_in2;
    logic [3:0]  sel_ctr;

    function automatic logic is_legal(input logic [3:0] code);
        case (code)
            4'b0000, 4'b0001, 4'b0010,
            4'b0110, 4'b0111, 4'b1100: is_legal = 1'b1;
            default:                   is_legal = 1'b0;
        endcase
    endfunction

    // On a tie the requester that was not served last wins.
    always_comb begin
        take0   = (state == IDLE) && bus.req0_valid && (!bus.req1_valid || last_grant);
        take1   = (state == IDLE) && bus.req1_valid && (!bus.req0_valid || !last_grant);
        accept  = take0 || take1;
        sel_in1 = take1 ? bus.req1_in1 : bus.req0_in1;
        sel_in2 = take1 ? bus.req1_in2 : bus.req0_in2;
        sel_ctr = take1 ? bus.req1_ctr : bus.req0_ctr;
        legal   = is_legal(sel_ctr);
        done    = (state == RESP) && (grant ? bus.rsp1_ready : bus.rsp0_ready);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = legal ? EXEC : RESP;
                end
            end
            EXEC:    state_nxt = RESP;
            RESP: begin
                if (done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
            grant      <= 1'b0;
            alu_a      <= 32'd0;
            alu_b      <= 32'd0;
            alu_op     <= 4'd0;
            result     <= 32'd0;
            zero_flag  <= 1'b0;
            err_flag   <= 1'b0;
            op_count   <= '0;
        end else begin
            if (accept) begin
                grant <= take1;
                if (legal) begin
                    alu_a  <= sel_in1;
                    alu_b  <= sel_in2;
                    alu_op <= sel_ctr;
                end else begin
                    // Rejected codes never reach the ALU; answer directly.
                    result    <= 32'd0;
                    zero_flag <= 1'b0;
                    err_flag  <= 1'b1;
                end
            end
            if (state == EXEC) begin
                result    <= bus.alu_res;
                zero_flag <= bus.alu_zero;
                err_flag  <= 1'b0;
            end
            if (done) begin
                last_grant <= grant;
                op_count   <= op_count + CNT_W'(1);
            end
        end
    end

    assign bus.req0_ready = take0;
    assign bus.req1_ready = take1;
    assign bus.rsp0_valid = (state == RESP) && !grant;
    assign bus.rsp1_valid = (state == RESP) && grant;
    assign bus.rsp_res    = result;
    assign bus.rsp_zero   = zero_flag;
    assign bus.rsp_err    = err_flag;
    assign bus.alu_input1 = alu_a;
    assign bus.alu_input2 = alu_b;
    assign bus.alu_ctr    = alu_op;
    assign bus.alu_src    = 1'b0;
    assign busy           = (state != IDLE);
endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// tb_alu_arbiter : directed table-driven bench for alu_arbiter
// Revision 1.0
// ============================================================================
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_arbiter_if ifc ();
    alu_arbiter_if ifc2 ();
    logic [15:0] op_count;
    logic        busy;
    logic [1:0]  op_count2;
    logic        busy2;

    alu_arbiter #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .bus(ifc), .op_count(op_count), .busy(busy)
    );
    alu_arbiter #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .bus(ifc2), .op_count(op_count2), .busy(busy2)
    );

    function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'b0000: alu_f = a & b;
            4'b0001: alu_f = a | b;
            4'b0010: alu_f = a + b;
            4'b0110: alu_f = a - b;
            4'b0111: alu_f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: alu_f = ~(a | b);
            default: alu_f = 32'd0;
        endcase
    endfunction

    assign ifc.alu_res   = alu_f(ifc.alu_ctr, ifc.alu_input1, ifc.alu_input2);
    assign ifc.alu_zero  = (ifc.alu_res == 32'd0);
    assign ifc2.alu_res  = alu_f(ifc2.alu_ctr, ifc2.alu_input1, ifc2.alu_input2);
    assign ifc2.alu_zero = (ifc2.alu_res == 32'd0);

    typedef struct {
        bit          n;
        logic [3:0]  ctr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        bit          zero;
        bit          err;
        int          lat;
    } vec_t;

    vec_t vecs[9];
    int   checks = 0;
    int   errors = 0;
    int   opm = 0;
    logic [3:0] last_ctr = 4'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit n, input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        if (!n) begin
            ifc.req0_valid = v; ifc.req0_ctr = c; ifc.req0_in1 = a; ifc.req0_in2 = b;
        end else begin
            ifc.req1_valid = v; ifc.req1_ctr = c; ifc.req1_in1 = a; ifc.req1_in2 = b;
        end
    endtask

    // Counts negedges from the call until a response appears (bounded).
    task automatic wait_rsp(output bit seen, output bit which, output int lat);
        seen = 1'b0; which = 1'b0; lat = 0;
        while (!seen && lat < 12) begin
            @(negedge clk);
            lat++;
            if (ifc.rsp0_valid || ifc.rsp1_valid) begin
                seen  = 1'b1;
                which = ifc.rsp1_valid;
            end
        end
    endtask

    initial begin
        bit seen;
        bit which;
        int lat;
        int seq[5];

        seq = '{1, 2, 3, 0, 1};
        vecs[0] = '{1'b0, 4'b0010, 32'd7,          32'd5,          32'd12,         1'b0, 1'b0, 2};
        vecs[1] = '{1'b1, 4'b0000, 32'h0000_F0F0,  32'h0000_0FF0,  32'h0000_00F0,  1'b0, 1'b0, 2};
        vecs[2] = '{1'b0, 4'b0001, 32'hF000_0000,  32'h0000_0001,  32'hF000_0001,  1'b0, 1'b0, 2};
        vecs[3] = '{1'b1, 4'b0110, 32'd5,          32'd5,          32'd0,          1'b1, 1'b0, 2};
        vecs[4] = '{1'b0, 4'b0111, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1'b0, 2};
        vecs[5] = '{1'b1, 4'b1100, 32'd0,          32'd0,          32'hFFFF_FFFF,  1'b0, 1'b0, 2};
        vecs[6] = '{1'b1, 4'b1111, 32'd3,          32'd4,          32'd0,          1'b0, 1'b1, 1};
        vecs[7] = '{1'b0, 4'b0011, 32'd8,          32'd8,          32'd0,          1'b0, 1'b1, 1};
        vecs[8] = '{1'b1, 4'b0010, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0, 2};

        reset = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
        ifc.rsp0_ready = 1'b1;
        ifc.rsp1_ready = 1'b1;
        ifc2.req0_valid = 1'b0; ifc2.req0_ctr = 4'd0; ifc2.req0_in1 = 32'd0; ifc2.req0_in2 = 32'd0;
        ifc2.req1_valid = 1'b0; ifc2.req1_ctr = 4'd0; ifc2.req1_in1 = 32'd0; ifc2.req1_in2 = 32'd0;
        ifc2.rsp0_ready = 1'b1;
        ifc2.rsp1_ready = 1'b1;

        #12;
        chk("reset_busy",     32'(busy), 32'd0);
        chk("reset_op_count", 32'(op_count), 32'd0);
        chk("reset_rsp_valid", 32'({ifc.rsp0_valid, ifc.rsp1_valid, ifc.req0_ready, ifc.req1_ready}), 32'd0);
        chk("reset_rsp_res",  ifc.rsp_res, 32'd0);
        chk("reset_flags",    32'({ifc.rsp_zero, ifc.rsp_err, ifc.alu_src}), 32'd0);
        chk("reset_alu",      ifc.alu_input1 | ifc.alu_input2 | 32'(ifc.alu_ctr), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single-requester vectors, response ready held high.
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            drive(vecs[i].n, 1'b1, vecs[i].ctr, vecs[i].a, vecs[i].b);
            @(negedge clk);
            chk($sformatf("v%0d_req_ready", i), 32'(vecs[i].n ? ifc.req1_ready : ifc.req0_ready), 32'd1);
            @(posedge clk); #1;
            drive(vecs[i].n, 1'b0, 4'($urandom), $urandom, $urandom);
            wait_rsp(seen, which, lat);
            chk($sformatf("v%0d_seen", i), 32'(seen), 32'd1);
            chk($sformatf("v%0d_chan", i), 32'(which), 32'(vecs[i].n));
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d_res", i), ifc.rsp_res, vecs[i].res);
            chk($sformatf("v%0d_zero_err", i), 32'({ifc.rsp_zero, ifc.rsp_err}), 32'({vecs[i].zero, vecs[i].err}));
            if (vecs[i].err) begin
                chk($sformatf("v%0d_alu_ctr_hold", i), 32'(ifc.alu_ctr), 32'(last_ctr));
            end else begin
                chk($sformatf("v%0d_alu_ctr", i), 32'(ifc.alu_ctr), 32'(vecs[i].ctr));
                last_ctr = vecs[i].ctr;
            end
            @(posedge clk); #1;
            opm++;
            @(negedge clk);
            chk($sformatf("v%0d_op_count", i), 32'(op_count), 32'(opm));
            chk($sformatf("v%0d_idle", i), 32'(busy), 32'd0);
        end

        // Continuous contention: grants alternate, one legal op per 3 cycles.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 4'b0110, 32'd9, 32'd9);
        drive(1'b1, 1'b1, 4'b0111, 32'd3, 32'd4);
        for (int k = 0; k < 4; k++) begin
            wait_rsp(seen, which, lat);
            chk($sformatf("cont%0d_seen", k), 32'(seen), 32'd1);
            chk($sformatf("cont%0d_grant", k), 32'(which), 32'(k % 2));
            chk($sformatf("cont%0d_period", k), 32'(lat), 32'd3);
            chk($sformatf("cont%0d_res", k), ifc.rsp_res, (k % 2 == 1) ? 32'd1 : 32'd0);
            chk($sformatf("cont%0d_zero", k), 32'(ifc.rsp_zero), (k % 2 == 1) ? 32'd0 : 32'd1);
            @(posedge clk); #1;
        end
        drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
        opm += 4;
        @(negedge clk);
        chk("cont_op_count", 32'(op_count), 32'(opm));

        // Backpressure on channel 0 while requester 1 waits.
        @(posedge clk); #1;
        ifc.rsp0_ready = 1'b0;
        drive(1'b0, 1'b1, 4'b0010, 32'd100, 32'd23);
        drive(1'b1, 1'b1, 4'b0010, 32'd1, 32'd1);
        @(negedge clk);
        chk("bp_req_ready", 32'({ifc.req0_ready, ifc.req1_ready}), 32'b10);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        wait_rsp(seen, which, lat);
        chk("bp_latency", 32'(lat), 32'd2);
        for (int j = 0; j < 5; j++) begin
            chk($sformatf("bp%0d_valid", j), 32'({ifc.rsp0_valid, ifc.rsp1_valid, ifc.req1_ready}), 32'b100);
            chk($sformatf("bp%0d_res", j), ifc.rsp_res, 32'd123);
            chk($sformatf("bp%0d_op_count", j), 32'(op_count), 32'(opm));
            @(posedge clk); #1;
            if (j == 4) ifc.rsp0_ready = 1'b1;
            @(negedge clk);
        end
        chk("bp_still_valid", 32'(ifc.rsp0_valid), 32'd1);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
        opm++;
        @(negedge clk);
        chk("bp_done_op_count", 32'(op_count), 32'(opm));
        chk("bp_done_valid", 32'(ifc.rsp0_valid), 32'd0);

        // Asynchronous reset while the op is in EXEC.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 4'b0010, 32'd1, 32'd1);
        @(negedge clk);
        chk("rst_req_ready", 32'(ifc.req0_ready), 32'd1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        chk("rst_exec_busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_alu", ifc.alu_input1 | ifc.alu_input2 | 32'(ifc.alu_ctr), 32'd0);
        chk("rst_rsp", ifc.rsp_res | 32'({ifc.rsp_zero, ifc.rsp_err, ifc.rsp0_valid, ifc.rsp1_valid}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        opm = 0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk($sformatf("rst_quiet%0d", j), 32'({ifc.rsp0_valid, ifc.rsp1_valid, busy}), 32'd0);
        end

        // Narrow counter wraps after four completions.
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            ifc2.req0_valid = 1'b1;
            ifc2.req0_ctr   = 4'b1111;
            @(posedge clk); #1;
            ifc2.req0_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("w2_%0d_valid", k), 32'(ifc2.rsp0_valid), 32'd1);
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("w2_%0d_op_count", k), 32'(op_count2), 32'(seq[k]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
